dmi_req_arbiter: RTL and testbench

- Shares the single DMI request/response port of the debug module between two hosts: requester 0 (JTAG DTM) and requester 1 (direct DMI/DPI tap).
- Round-robin arbitration, one outstanding transaction at a time, response routed back to the granted host.
- Optional watchdog converts a hung DM access into a FAILED response.
- Sits between the TAP/DPI front-ends and the debug module inside the SoC top.

---
 rtl/dmi_arb_pkg.sv | 43 ++++
 rtl/dmi_arb_rr.sv | 25 ++
 rtl/dmi_req_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_dmi_req_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_arb_pkg.sv
// Shared types and constants for the DMI request arbiter.
//   state_e    : arbiter FSM states (IDLE -> REQ -> WAIT_RSP -> RSP)
//   DMI_OP_*   : DMI operation encodings
//   DMI_RESP_* : DMI response encodings
//   dmi_req_t  : latched request (addr, op, data); addr is stored at the
//                widest supported width and narrowed at the DM-side port
//   make_req   : builds a dmi_req_t from individual fields
package dmi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        RSP      = 2'd3
    } state_e;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_OK     = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

    localparam int DMI_ADDR_MAX_W = 32;

    typedef struct packed {
        logic [DMI_ADDR_MAX_W-1:0] addr;
        logic [1:0]                op;
        logic [31:0]               data;
    } dmi_req_t;

    function automatic dmi_req_t make_req(input logic [DMI_ADDR_MAX_W-1:0] addr,
                                          input logic [1:0]                op,
                                          input logic [31:0]               data);
        dmi_req_t r;
        r.addr = addr;
        r.op   = op;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/dmi_arb_rr.sv
// Two-way round-robin picker.
//   valid_i[1:0] : request valids of requester 1 and 0
//   last_i       : id of the most recent winner
//   grant_o      : some requester is valid
//   id_o         : winning requester id (only meaningful when grant_o=1)
// With a single valid requester it wins outright; with both valid, the one
// that did not win last time is chosen.
module dmi_arb_rr (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       id_o
);

    always_comb begin
        grant_o = |valid_i;
        case (valid_i)
            2'b01:   id_o = 1'b0;
            2'b10:   id_o = 1'b1;
            2'b11:   id_o = ~last_i;
            default: id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares the single DMI request/response port of the debug module between
// requester 0 (JTAG DTM) and requester 1 (direct DMI/DPI tap). One
// transaction is outstanding at a time; the response is routed back to the
// host that was granted.
//
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   reqN_valid/ready/addr/op/data: request channel from host N (N = 0, 1)
//   rspN_valid/ready/data/resp   : response channel back to host N
//   dmi_req_*                    : request channel to the debug module
//   dmi_rsp_*                    : response channel from the debug module
//
// Optional feature, macro DMI_ARB_TIMEOUT_EN: a watchdog turns a DM access
// that does not answer within TIMEOUT WAIT_RSP cycles into a FAILED
// response. The late DM answer is then swallowed (stale_q) before any new
// grant is made.
module dmi_req_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [1:0]        req0_op_i,
    input  logic [31:0]       req0_data_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [31:0]       rsp0_data_o,
    output logic [1:0]        rsp0_resp_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [1:0]        req1_op_i,
    input  logic [31:0]       req1_data_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [31:0]       rsp1_data_o,
    output logic [1:0]        rsp1_resp_o,

    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [ADDR_W-1:0] dmi_req_addr_o,
    output logic [1:0]        dmi_req_op_o,
    output logic [31:0]       dmi_req_data_o,
    input  logic              dmi_rsp_valid_i,
    output logic              dmi_rsp_ready_o,
    input  logic [31:0]       dmi_rsp_data_i,
    input  logic [1:0]        dmi_rsp_resp_i
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_id_q, gnt_id_d;
    dmi_req_t    gnt_req_q, gnt_req_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;

    logic        rr_grant, rr_id;
    logic        stale;
    logic        accept;
    logic        rsp_ready_sel;
    dmi_req_t    req0_pkt, req1_pkt;

    assign req0_pkt = make_req(DMI_ADDR_MAX_W'(req0_addr_i), req0_op_i, req0_data_i);
    assign req1_pkt = make_req(DMI_ADDR_MAX_W'(req1_addr_i), req1_op_i, req1_data_i);

    dmi_arb_rr u_rr (
        .valid_i ({req1_valid_i, req0_valid_i}),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .id_o    (rr_id)
    );

    assign accept        = (state_q == IDLE) && !stale && rr_grant;
    assign rsp_ready_sel = gnt_id_q ? rsp1_ready_i : rsp0_ready_i;

    // Only the low ADDR_W bits of the stored address ever reach the DM.
    logic unused_addr_ok;
    assign unused_addr_ok = ^gnt_req_q.addr;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;

    assign stale = stale_q;
`else
    logic unused_timeout_ok;
    assign unused_timeout_ok = (TIMEOUT < 1);
    assign stale = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_id_q   <= 1'b0;
            gnt_req_q  <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_id_q   <= gnt_id_d;
            gnt_req_q  <= gnt_req_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_id_d   = gnt_id_q;
        gnt_req_d  = gnt_req_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        stale_d    = stale_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = REQ;
                    last_d    = rr_id;
                    gnt_id_d  = rr_id;
                    gnt_req_d = rr_id ? req1_pkt : req0_pkt;
                end
            end
            REQ: begin
                if (dmi_req_ready_i) begin
                    state_d = WAIT_RSP;
`ifdef DMI_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_RSP: begin
                if (dmi_rsp_valid_i) begin
                    state_d    = RSP;
                    rsp_data_d = dmi_rsp_data_i;
                    rsp_resp_d = dmi_rsp_resp_i;
                end
`ifdef DMI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d    = RSP;
                    rsp_data_d = '0;
                    rsp_resp_d = DMI_RESP_FAILED;
                    stale_d    = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RSP: begin
                if (rsp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DMI_ARB_TIMEOUT_EN
        // stale_q can only be set in RSP or IDLE (IDLE stops granting while
        // it is set), so this never competes with the REQ/WAIT_RSP counter use.
        if (stale_q) begin
            if (dmi_rsp_valid_i || (cnt_q == CNT_LAST)) begin
                stale_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    // Output logic
    always_comb begin
        req0_ready_o    = 1'b0;
        req1_ready_o    = 1'b0;
        dmi_req_valid_o = 1'b0;
        dmi_req_addr_o  = '0;
        dmi_req_op_o    = '0;
        dmi_req_data_o  = '0;
        dmi_rsp_ready_o = (state_q == WAIT_RSP) || stale;
        rsp0_valid_o    = 1'b0;
        rsp0_data_o     = '0;
        rsp0_resp_o     = '0;
        rsp1_valid_o    = 1'b0;
        rsp1_data_o     = '0;
        rsp1_resp_o     = '0;

        // Ready is combinational from the valids, so it must be masked
        // while reset holds the FSM in IDLE.
        if (accept && !rst_i) begin
            req0_ready_o = !rr_id;
            req1_ready_o = rr_id;
        end

        if (state_q == REQ) begin
            dmi_req_valid_o = 1'b1;
            dmi_req_addr_o  = gnt_req_q.addr[ADDR_W-1:0];
            dmi_req_op_o    = gnt_req_q.op;
            dmi_req_data_o  = gnt_req_q.data;
        end

        if (state_q == RSP) begin
            if (gnt_id_q) begin
                rsp1_valid_o = 1'b1;
                rsp1_data_o  = rsp_data_q;
                rsp1_resp_o  = rsp_resp_q;
            end else begin
                rsp0_valid_o = 1'b1;
                rsp0_data_o  = rsp_data_q;
                rsp0_resp_o  = rsp_resp_q;
            end
        end
    end

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Self-checking bench for dmi_req_arbiter. Inputs are driven right after the
// falling clock edge and outputs are sampled before the next rising edge.
// Expected responses go into a scoreboard queue when a DM answer is
// scheduled and are popped when a host response appears.
module tb_dmi_req_arbiter;
    import dmi_arb_pkg::*;

    localparam int ADDR_W  = 7;
    localparam int TIMEOUT = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req0_valid_i, req0_ready_o;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [1:0]        req0_op_i;
    logic [31:0]       req0_data_i;
    logic              rsp0_valid_o, rsp0_ready_i;
    logic [31:0]       rsp0_data_o;
    logic [1:0]        rsp0_resp_o;
    logic              req1_valid_i, req1_ready_o;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [1:0]        req1_op_i;
    logic [31:0]       req1_data_i;
    logic              rsp1_valid_o, rsp1_ready_i;
    logic [31:0]       rsp1_data_o;
    logic [1:0]        rsp1_resp_o;
    logic              dmi_req_valid_o, dmi_req_ready_i;
    logic [ADDR_W-1:0] dmi_req_addr_o;
    logic [1:0]        dmi_req_op_o;
    logic [31:0]       dmi_req_data_o;
    logic              dmi_rsp_valid_i, dmi_rsp_ready_o;
    logic [31:0]       dmi_rsp_data_i;
    logic [1:0]        dmi_rsp_resp_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    dmi_req_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_addr_i(req0_addr_i), .req0_op_i(req0_op_i), .req0_data_i(req0_data_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp0_data_o(rsp0_data_o), .rsp0_resp_o(rsp0_resp_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_addr_i(req1_addr_i), .req1_op_i(req1_op_i), .req1_data_i(req1_data_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp1_data_o(rsp1_data_o), .rsp1_resp_o(rsp1_resp_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
        .dmi_req_data_o(dmi_req_data_o),
        .dmi_rsp_valid_i(dmi_rsp_valid_i), .dmi_rsp_ready_o(dmi_rsp_ready_o),
        .dmi_rsp_data_i(dmi_rsp_data_i), .dmi_rsp_resp_i(dmi_rsp_resp_i)
    );

    // {valid, resp, data} seen by host N
    function automatic logic [34:0] rsp_obs(input int host);
        return (host == 1) ? {rsp1_valid_o, rsp1_resp_o, rsp1_data_o}
                           : {rsp0_valid_o, rsp0_resp_o, rsp0_data_o};
    endfunction

    task automatic idle_inputs();
        req0_valid_i = 0; req0_addr_i = '0; req0_op_i = '0; req0_data_i = '0;
        req1_valid_i = 0; req1_addr_i = '0; req1_op_i = '0; req1_data_i = '0;
        rsp0_ready_i = 1; rsp1_ready_i = 1;
        dmi_req_ready_i = 0; dmi_rsp_valid_i = 0; dmi_rsp_data_i = '0; dmi_rsp_resp_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1;
        idle_inputs();
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 0;
    endtask

    // Called in the first REQ cycle: accepts the request, then answers it.
    task automatic dm_serve(input logic [31:0] rd, input logic [1:0] rr, output bit ok);
        dmi_req_ready_i = 1;
        @(negedge clk_i);
        dmi_req_ready_i = 0;
        ok = dmi_rsp_ready_o;
        dmi_rsp_valid_i = 1; dmi_rsp_data_i = rd; dmi_rsp_resp_i = rr;
        @(negedge clk_i);
        dmi_rsp_valid_i = 0; dmi_rsp_data_i = '0; dmi_rsp_resp_i = '0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        while (!(rsp0_valid_o || rsp1_valid_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        ok = rsp0_valid_o || rsp1_valid_o;
    endtask

    task automatic test_reset();
        req0_valid_i = 1; req1_valid_i = 1;
        repeat (2) @(negedge clk_i);
        #1;
        total++;
        if ({req0_ready_o, req1_ready_o, dmi_req_valid_o, dmi_rsp_ready_o, rsp0_valid_o, rsp1_valid_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {req0_ready_o, req1_ready_o, dmi_req_valid_o, dmi_rsp_ready_o, rsp0_valid_o, rsp1_valid_o});
        end
        total++;
        if ({dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o} !== 41'h0) begin
            bad++;
            $display("FAIL reset_dmi_fields got=%h exp=0", {dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o});
        end
        total++;
        if ({rsp0_resp_o, rsp0_data_o, rsp1_resp_o, rsp1_data_o} !== 68'h0) begin
            bad++;
            $display("FAIL reset_rsp_fields got=%h exp=0", {rsp0_resp_o, rsp0_data_o, rsp1_resp_o, rsp1_data_o});
        end
        req0_valid_i = 0; req1_valid_i = 0;
        rst_i = 0;
    endtask

    task automatic test_single_read();
        exp_t e;
        bit ok;
        @(negedge clk_i);
        req0_valid_i = 1; req0_addr_i = 7'h11; req0_op_i = DMI_OP_READ; req0_data_i = '0;
        #1;
        total++;
        if ({req1_ready_o, req0_ready_o, dmi_req_valid_o} !== 3'b010) begin
            bad++;
            $display("FAIL single_grant got=%b exp=010", {req1_ready_o, req0_ready_o, dmi_req_valid_o});
        end
        @(negedge clk_i);
        req0_valid_i = 0;
        total++;
        if ({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o} !== {1'b1, 7'h11, DMI_OP_READ}) begin
            bad++;
            $display("FAIL single_dmi_req got=%h exp=%h", {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o},
                     {1'b1, 7'h11, DMI_OP_READ});
        end
        sb.push_back('{0, 32'hDEADBEEF, DMI_RESP_OK});
        dm_serve(32'hDEADBEEF, DMI_RESP_OK, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL single_dmi_rsp_ready got=%b exp=1", ok);
        end
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (rsp_obs(e.host) !== {1'b1, e.resp, e.data}) begin
            bad++;
            $display("FAIL single_rsp got=%h exp=%h", rsp_obs(e.host), {1'b1, e.resp, e.data});
        end
        total++;
        if (rsp_obs(1 - e.host) !== 35'h0) begin
            bad++;
            $display("FAIL single_other_host got=%h exp=0", rsp_obs(1 - e.host));
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit ok;
        int exp_id;
        logic [31:0] rd;
        logic [40:0] exp_f;
        do_reset();
        req0_addr_i = 7'h10; req0_op_i = DMI_OP_WRITE; req0_data_i = 32'h1;
        req1_addr_i = 7'h04; req1_op_i = DMI_OP_READ;  req1_data_i = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            req0_valid_i = 1; req1_valid_i = 1;
            #1;
            exp_id = k % 2;
            total++;
            if ({req1_ready_o, req0_ready_o} !== ((exp_id == 1) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_order txn%0d got=%b exp_id=%0d", k, {req1_ready_o, req0_ready_o}, exp_id);
            end
            @(negedge clk_i);
            exp_f = (exp_id == 1) ? {7'h04, DMI_OP_READ, 32'h0} : {7'h10, DMI_OP_WRITE, 32'h1};
            total++;
            if ({req1_ready_o, req0_ready_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o} !== {2'b00, exp_f}) begin
                bad++;
                $display("FAIL rr_fields txn%0d got=%h exp=%h", k,
                         {req1_ready_o, req0_ready_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, {2'b00, exp_f});
            end
            rd = 32'hA000_0000 | 32'(k);
            sb.push_back('{exp_id, rd, DMI_RESP_OK});
            dm_serve(rd, DMI_RESP_OK, ok);
            wait_rsp(ok);
            e = sb.pop_front();
            total++;
            if (!ok || rsp_obs(e.host) !== {1'b1, e.resp, e.data} || rsp_obs(1 - e.host) !== 35'h0) begin
                bad++;
                $display("FAIL rr_rsp txn%0d got0=%h got1=%h exp_host=%0d exp=%h", k,
                         rsp_obs(0), rsp_obs(1), e.host, {1'b1, e.resp, e.data});
            end
        end
        req0_valid_i = 0; req1_valid_i = 0;
    endtask

    task automatic test_req_stall();
        exp_t e;
        bit ok;
        do_reset();
        req0_addr_i = 7'h2A; req0_op_i = DMI_OP_WRITE; req0_data_i = 32'hCAFEF00D;
        req1_addr_i = 7'h05; req1_op_i = DMI_OP_READ;  req1_data_i = 32'h0;
        @(negedge clk_i);
        req0_valid_i = 1; req1_valid_i = 1;
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, req1_ready_o, req0_ready_o} !==
                {1'b1, 7'h2A, DMI_OP_WRITE, 32'hCAFEF00D, 2'b00}) begin
                bad++;
                $display("FAIL stall_hold cyc%0d got=%h exp=%h", i,
                         {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, req1_ready_o, req0_ready_o},
                         {1'b1, 7'h2A, DMI_OP_WRITE, 32'hCAFEF00D, 2'b00});
            end
            @(negedge clk_i);
        end
        sb.push_back('{0, 32'h0, DMI_RESP_OK});
        dm_serve(32'h0, DMI_RESP_OK, ok);
        wait_rsp(ok);
        req0_valid_i = 0; req1_valid_i = 0;
        e = sb.pop_front();
        total++;
        if (!ok || rsp_obs(e.host) !== {1'b1, e.resp, e.data} || rsp_obs(1 - e.host) !== 35'h0) begin
            bad++;
            $display("FAIL stall_rsp got0=%h got1=%h exp=%h", rsp_obs(0), rsp_obs(1), {1'b1, e.resp, e.data});
        end
    endtask

    task automatic test_rsp_backpressure();
        exp_t e;
        bit ok;
        do_reset();
        rsp1_ready_i = 0;
        @(negedge clk_i);
        req1_valid_i = 1; req1_addr_i = 7'h33; req1_op_i = DMI_OP_READ;
        @(negedge clk_i);
        req1_valid_i = 0;
        req0_valid_i = 1; req0_addr_i = 7'h44; req0_op_i = DMI_OP_READ;
        sb.push_back('{1, 32'h1234_5678, DMI_RESP_OK});
        dm_serve(32'h1234_5678, DMI_RESP_OK, ok);
        wait_rsp(ok);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({rsp1_valid_o, rsp1_data_o, rsp0_valid_o, req0_ready_o} !== {1'b1, 32'h1234_5678, 2'b00}) begin
                bad++;
                $display("FAIL bp_hold cyc%0d got=%h exp=%h", i,
                         {rsp1_valid_o, rsp1_data_o, rsp0_valid_o, req0_ready_o}, {1'b1, 32'h1234_5678, 2'b00});
            end
            @(negedge clk_i);
        end
        rsp1_ready_i = 1;
        #1;
        e = sb.pop_front();
        total++;
        if (rsp_obs(e.host) !== {1'b1, e.resp, e.data} || req0_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got=%h req0_ready=%b exp=%h req0_ready=0",
                     rsp_obs(e.host), req0_ready_o, {1'b1, e.resp, e.data});
        end
        @(negedge clk_i);
        #1;
        total++;
        if ({req1_ready_o, req0_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL bp_next_grant got=%b exp=01", {req1_ready_o, req0_ready_o});
        end
        @(negedge clk_i);
        req0_valid_i = 0;
        sb.push_back('{0, 32'h0000_4444, DMI_RESP_OK});
        dm_serve(32'h0000_4444, DMI_RESP_OK, ok);
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (!ok || rsp_obs(e.host) !== {1'b1, e.resp, e.data} || rsp_obs(1 - e.host) !== 35'h0) begin
            bad++;
            $display("FAIL bp_second_rsp got0=%h got1=%h exp=%h", rsp_obs(0), rsp_obs(1), {1'b1, e.resp, e.data});
        end
    endtask

`ifdef DMI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit ok;
        int n;
        do_reset();
        @(negedge clk_i);
        req0_valid_i = 1; req0_addr_i = 7'h20; req0_op_i = DMI_OP_READ;
        @(negedge clk_i);
        req0_valid_i = 0;
        dmi_req_ready_i = 1;
        @(negedge clk_i);
        dmi_req_ready_i = 0;
        n = 0;
        while (!rsp0_valid_o && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        total++;
        if (n !== TIMEOUT) begin
            bad++;
            $display("FAIL timeout_cycles got=%0d exp=%0d", n, TIMEOUT);
        end
        sb.push_back('{0, 32'h0, DMI_RESP_FAILED});
        e = sb.pop_front();
        total++;
        if (rsp_obs(e.host) !== {1'b1, e.resp, e.data}) begin
            bad++;
            $display("FAIL timeout_rsp got=%h exp=%h", rsp_obs(e.host), {1'b1, e.resp, e.data});
        end
        @(negedge clk_i);
        req1_valid_i = 1; req1_addr_i = 7'h06; req1_op_i = DMI_OP_READ;
        dmi_rsp_valid_i = 1; dmi_rsp_data_i = 32'h0BAD_0BAD; dmi_rsp_resp_i = DMI_RESP_OK;
        #1;
        total++;
        if ({req1_ready_o, dmi_rsp_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL stale_block got=%b exp=01", {req1_ready_o, dmi_rsp_ready_o});
        end
        @(negedge clk_i);
        dmi_rsp_valid_i = 0; dmi_rsp_data_i = '0;
        #1;
        total++;
        if ({rsp0_valid_o, rsp1_valid_o, req1_ready_o} !== 3'b001) begin
            bad++;
            $display("FAIL stale_swallow got=%b exp=001", {rsp0_valid_o, rsp1_valid_o, req1_ready_o});
        end
        @(negedge clk_i);
        req1_valid_i = 0;
        sb.push_back('{1, 32'h0000_55AA, DMI_RESP_OK});
        dm_serve(32'h0000_55AA, DMI_RESP_OK, ok);
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (!ok || rsp_obs(e.host) !== {1'b1, e.resp, e.data} || rsp_obs(1 - e.host) !== 35'h0) begin
            bad++;
            $display("FAIL timeout_after_rsp got0=%h got1=%h exp=%h", rsp_obs(0), rsp_obs(1), {1'b1, e.resp, e.data});
        end
    endtask
`endif

    task automatic test_reset_mid_txn();
        exp_t e;
        bit ok;
        do_reset();
        @(negedge clk_i);
        req0_valid_i = 1; req0_addr_i = 7'h12; req0_op_i = DMI_OP_READ;
        @(negedge clk_i);
        req0_valid_i = 0;
        dmi_req_ready_i = 1;
        @(negedge clk_i);
        dmi_req_ready_i = 0;
        req1_valid_i = 1; req1_addr_i = 7'h07; req1_op_i = DMI_OP_READ;
        #1;
        total++;
        if ({dmi_rsp_ready_o, req1_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_wait got=%b exp=10", {dmi_rsp_ready_o, req1_ready_o});
        end
        rst_i = 1;
        #1;
        total++;
        if ({req0_ready_o, req1_ready_o, dmi_req_valid_o, dmi_rsp_ready_o, rsp0_valid_o, rsp1_valid_o,
             dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, rsp0_data_o, rsp1_data_o} !== 111'h0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b%b%b%b%b%b addr=%h data0=%h data1=%h exp=0",
                     req0_ready_o, req1_ready_o, dmi_req_valid_o, dmi_rsp_ready_o, rsp0_valid_o, rsp1_valid_o,
                     dmi_req_addr_o, rsp0_data_o, rsp1_data_o);
        end
        @(negedge clk_i);
        rst_i = 0;
        #1;
        total++;
        if ({req1_ready_o, req0_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_regrant got=%b exp=10", {req1_ready_o, req0_ready_o});
        end
        @(negedge clk_i);
        req1_valid_i = 0;
        total++;
        if ({dmi_req_valid_o, dmi_req_addr_o} !== {1'b1, 7'h07}) begin
            bad++;
            $display("FAIL midrst_dmi_req got=%h exp=%h", {dmi_req_valid_o, dmi_req_addr_o}, {1'b1, 7'h07});
        end
        sb.push_back('{1, 32'h7777_0007, DMI_RESP_OK});
        dm_serve(32'h7777_0007, DMI_RESP_OK, ok);
        wait_rsp(ok);
        e = sb.pop_front();
        total++;
        if (!ok || rsp_obs(e.host) !== {1'b1, e.resp, e.data} || rsp_obs(1 - e.host) !== 35'h0) begin
            bad++;
            $display("FAIL midrst_rsp got0=%h got1=%h exp=%h", rsp_obs(0), rsp_obs(1), {1'b1, e.resp, e.data});
        end
    endtask

    initial begin
        rst_i = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_req_stall();
        test_rsp_backpressure();
`ifdef DMI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_txn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
